// File: rtl/bdp_pkg.sv
// Shared types for the bus datapath: opcodes, sequencer states and bus source selects.
// Also holds small opcode classification helpers used by the top and the ALU.
package bdp_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_MUL  = 4'd6,
        OP_MFHI = 4'd7,
        OP_MFLO = 4'd8,
        OP_LDI  = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_RESP = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_RA   = 3'd1,
        BUS_RB   = 3'd2,
        BUS_ZLO  = 3'd3,
        BUS_ZHI  = 3'd4,
        BUS_HI   = 3'd5,
        BUS_LO   = 3'd6,
        BUS_IMM  = 3'd7
    } bus_src_e;

    localparam int OP_W = 4;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_LDI;
    endfunction

    // Single-transfer ops: one bus move straight into R[rc].
    function automatic logic op_is_move(input logic [OP_W-1:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_LDI);
    endfunction

    function automatic logic op_is_mul(input logic [OP_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/bdp_alu.sv
// Combinational ALU fed by the Y latch and the bus; result is double width so
// MUL can deliver both halves, other ops are zero-extended.
module bdp_alu
    import bdp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]          op,
    input  logic [DATA_W-1:0]   y,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   narrow;
    logic [2*DATA_W-1:0] product;

    assign shamt   = b[SH_W-1:0];
    assign product = {{DATA_W{1'b0}}, y} * {{DATA_W{1'b0}}, b};

    always_comb begin
        narrow = '0;
        case (op)
            OP_ADD:  narrow = y + b;
            OP_SUB:  narrow = y - b;
            OP_AND:  narrow = y & b;
            OP_OR:   narrow = y | b;
            OP_SHL:  narrow = y << shamt;
            OP_SHR:  narrow = y >> shamt;
            default: narrow = '0;
        endcase
    end

    assign result = (op == OP_MUL) ? product : {{DATA_W{1'b0}}, narrow};

endmodule

// File: rtl/bus_datapath_gen.sv
// Single-bus datapath: register file, Y/Z latches and HI/LO, sequenced by a
// six-state FSM that picks exactly one bus source per cycle.
module bus_datapath_gen
    import bdp_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    parameter  int R0_ZERO  = 1,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              clear,
    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; rsp_valid is a single-cycle pulse, no backpressure.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_ra,
    input  logic [RA_W-1:0]   cmd_rb,
    input  logic [RA_W-1:0]   cmd_rc,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] bus_mon,
    output logic [2:0]        fsm_state
);

    state_e   state, state_next;
    bus_src_e bus_sel;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [3:0]          op_q;
    logic [RA_W-1:0]     ra_q, rb_q, rc_q;
    logic [DATA_W-1:0]   imm_q, y_q, hi_q, lo_q;
    logic [2*DATA_W-1:0] z_q;
    logic                err_q;

    logic [DATA_W-1:0]   bus, a_val, b_val;
    logic [2*DATA_W-1:0] alu_res;
    logic                accept, reg_we, y_we, z_we, lo_we, hi_we, rc_writable;

    assign accept      = cmd_valid && (state == S_IDLE);
    assign a_val       = (R0_ZERO != 0 && ra_q == '0) ? '0 : regs[ra_q];
    assign b_val       = (R0_ZERO != 0 && rb_q == '0) ? '0 : regs[rb_q];
    assign rc_writable = !(R0_ZERO != 0 && rc_q == '0);

    bdp_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .y      (y_q),
        .b      (bus),
        .result (alu_res)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus_sel    = BUS_NONE;
        reg_we     = 1'b0;
        y_we       = 1'b0;
        z_we       = 1'b0;
        lo_we      = 1'b0;
        hi_we      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) state_next = op_legal(cmd_op) ? S_T1 : S_RESP;
            end
            S_T1: begin
                case (op_q)
                    OP_MFHI: bus_sel = BUS_HI;
                    OP_MFLO: bus_sel = BUS_LO;
                    OP_LDI:  bus_sel = BUS_IMM;
                    default: bus_sel = BUS_RA;
                endcase
                if (op_is_move(op_q)) begin
                    reg_we     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    y_we       = 1'b1;
                    state_next = S_T2;
                end
            end
            S_T2: begin
                bus_sel    = BUS_RB;
                z_we       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                bus_sel    = BUS_ZLO;
                reg_we     = 1'b1;
                lo_we      = op_is_mul(op_q);
                state_next = op_is_mul(op_q) ? S_T4 : S_RESP;
            end
            S_T4: begin
                bus_sel    = BUS_ZHI;
                hi_we      = 1'b1;
                state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus = '0;
        case (bus_sel)
            BUS_RA:  bus = a_val;
            BUS_RB:  bus = b_val;
            BUS_ZLO: bus = z_q[DATA_W-1:0];
            BUS_ZHI: bus = z_q[2*DATA_W-1:DATA_W];
            BUS_HI:  bus = hi_q;
            BUS_LO:  bus = lo_q;
            BUS_IMM: bus = imm_q;
            default: bus = '0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= cmd_op;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            rc_q  <= cmd_rc;
            imm_q <= cmd_imm;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            y_q  <= '0;
            z_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (y_we)  y_q  <= bus;
            if (z_we)  z_q  <= alu_res;
            if (lo_we) lo_q <= bus;
            if (hi_we) hi_q <= bus;
        end
    end

    // Sources were latched into Y/Z before this write, so rc aliasing ra/rb is safe.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_we && rc_writable) begin
            regs[rc_q] <= bus;
        end
    end

    // rsp_data reports the bus value even when the R0 write is discarded.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rsp_data <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                err_q <= !op_legal(cmd_op);
                if (!op_legal(cmd_op)) rsp_data <= '0;
            end
            if (reg_we) rsp_data <= bus;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign bus_mon   = bus;
    assign fsm_state = state;

endmodule

// File: tb/tb_bus_datapath_gen.sv
// Bench for bus_datapath_gen: three instances (32-bit R0 zero, 32-bit R0 writable,
// 16-bit with 32 registers) driven in lockstep and checked against a reference model.
module tb_bus_datapath_gen;

    logic        clock = 1'b0;
    logic        clear;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_ra, cmd_rb, cmd_rc;
    logic [31:0] cmd_imm;

    logic        rdy0, rdy1, rdy2, rv0, rv1, rv2, re0, re1, re2;
    logic [31:0] rd0, rd1, bm0, bm1;
    logic [15:0] rd2, bm2;
    logic [2:0]  st0, st1, st2;

    int n_pass  = 0;
    int n_total = 0;

    localparam int EXP_W = 101;
    logic [EXP_W-1:0] exp_q[$];

    int          mw[3] = '{32, 32, 16};
    int          mn[3] = '{16, 16, 32};
    bit          mz[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_regs[3][32];
    logic [31:0] m_hi[3];
    logic [31:0] m_lo[3];

    logic [31:0] cap_d[3];
    logic        cap_err;
    int          cap_lat;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  ra, rb, rc;
        logic [31:0] imm;
        logic [31:0] data;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vt[18];

    always #5 clock = ~clock;

    bus_datapath_gen #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1)) u_dut0 (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra[3:0]), .cmd_rb(cmd_rb[3:0]), .cmd_rc(cmd_rc[3:0]),
        .cmd_imm(cmd_imm), .rsp_valid(rv0), .rsp_data(rd0), .rsp_err(re0),
        .bus_mon(bm0), .fsm_state(st0)
    );

    bus_datapath_gen #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(0)) u_dut1 (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra[3:0]), .cmd_rb(cmd_rb[3:0]), .cmd_rc(cmd_rc[3:0]),
        .cmd_imm(cmd_imm), .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1),
        .bus_mon(bm1), .fsm_state(st1)
    );

    bus_datapath_gen #(.DATA_W(16), .NUM_REGS(32), .R0_ZERO(1)) u_dut2 (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
        .cmd_imm(cmd_imm[15:0]), .rsp_valid(rv2), .rsp_data(rd2), .rsp_err(re2),
        .bus_mon(bm2), .fsm_state(st2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 32; r++) m_regs[k][r] = '0;
            m_hi[k] = '0;
            m_lo[k] = '0;
        end
    endtask

    task automatic model_step(input logic [3:0] op, input logic [4:0] ra, rb, rc,
                              input logic [31:0] imm);
        logic [31:0] d[3];
        logic        err;
        int          lat;
        err = (op > 4'd9);
        lat = err ? 1 : (op <= 4'd5) ? 4 : (op == 4'd6) ? 5 : 2;
        for (int k = 0; k < 3; k++) begin
            int          ia, ib, ic;
            logic [63:0] mask, a, b, r, p;
            ia   = int'(ra) % mn[k];
            ib   = int'(rb) % mn[k];
            ic   = int'(rc) % mn[k];
            mask = (64'd1 << mw[k]) - 64'd1;
            a    = (mz[k] && ia == 0) ? 64'd0 : {32'd0, m_regs[k][ia]};
            b    = (mz[k] && ib == 0) ? 64'd0 : {32'd0, m_regs[k][ib]};
            r    = 64'd0;
            case (op)
                4'd0: r = (a + b) & mask;
                4'd1: r = (a - b) & mask;
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = (a << (b % 64'(mw[k]))) & mask;
                4'd5: r = a >> (b % 64'(mw[k]));
                4'd6: begin
                    p        = a * b;
                    r        = p & mask;
                    m_lo[k]  = r[31:0];
                    m_hi[k]  = 32'((p >> mw[k]) & mask);
                end
                4'd7: r = {32'd0, m_hi[k]};
                4'd8: r = {32'd0, m_lo[k]};
                4'd9: r = {32'd0, imm} & mask;
                default: r = 64'd0;
            endcase
            if (!err && !(mz[k] && ic == 0)) m_regs[k][ic] = r[31:0];
            d[k] = r[31:0];
        end
        exp_q.push_back({4'(lat), err, d[2], d[1], d[0]});
    endtask

    // Issue one command from a negedge; returns at the negedge after the response cycle.
    task automatic do_cmd(input logic [3:0] op, input logic [4:0] ra, rb, rc,
                          input logic [31:0] imm, input bit hold);
        int               guard = 0;
        bit               seen  = 1'b0;
        bit               busy_ok = 1'b1;
        logic [EXP_W-1:0] e;
        while (!(rdy0 && rdy1 && rdy2) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("ready_wait", 64'(guard < 20), 64'd1);
        model_step(op, ra, rb, rc, imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rc    = rc;
        cmd_imm   = imm;
        @(posedge clock);
        cap_lat = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clock);
            if (!hold) cmd_valid = 1'b0;
            if (rdy0 || rdy1 || rdy2) busy_ok = 1'b0;
            if (rv0 || rv1 || rv2) begin
                seen     = 1'b1;
                cap_lat  = c;
                cap_d[0] = rd0;
                cap_d[1] = rd1;
                cap_d[2] = {16'd0, rd2};
                cap_err  = re0;
                check("rsp_valid_all", {61'd0, rv2, rv1, rv0}, 64'd7);
                check("rsp_err_all", {61'd0, re2, re1, re0}, {61'd0, {3{re0}}});
            end
        end
        e = exp_q.pop_front();
        check("latency", 64'(cap_lat), 64'(e[100:97]));
        check("busy_not_ready", 64'(busy_ok), 64'd1);
        check("rsp_err", 64'(cap_err), 64'(e[96]));
        check("rsp_data_w32_r0z", 64'(cap_d[0]), 64'(e[31:0]));
        check("rsp_data_w32_r0w", 64'(cap_d[1]), 64'(e[63:32]));
        check("rsp_data_w16", 64'(cap_d[2]), 64'(e[95:64]));
        @(negedge clock);
        check("idle_after_rsp", {60'd0, rv0, rdy0, rdy1, rdy2}, 64'd7);
        check("rsp_data_held", 64'(rd0), 64'(cap_d[0]));
        check("bus_idle_zero", {bm0, bm2}, 64'd0);
    endtask

    initial begin
        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rc    = '0;
        cmd_imm   = '0;
        model_reset();

        vt[0]  = '{4'd9, 5'd0, 5'd0, 5'd1,  32'd5,          32'd5,          1'b0, 2};
        vt[1]  = '{4'd9, 5'd0, 5'd0, 5'd2,  32'd7,          32'd7,          1'b0, 2};
        vt[2]  = '{4'd0, 5'd1, 5'd2, 5'd3,  32'd0,          32'd12,         1'b0, 4};
        vt[3]  = '{4'd1, 5'd1, 5'd2, 5'd4,  32'd0,          32'hFFFF_FFFE,  1'b0, 4};
        vt[4]  = '{4'd2, 5'd1, 5'd2, 5'd5,  32'd0,          32'd5,          1'b0, 4};
        vt[5]  = '{4'd3, 5'd1, 5'd2, 5'd6,  32'd0,          32'd7,          1'b0, 4};
        vt[6]  = '{4'd4, 5'd2, 5'd1, 5'd7,  32'd0,          32'd224,        1'b0, 4};
        vt[7]  = '{4'd5, 5'd7, 5'd1, 5'd8,  32'd0,          32'd7,          1'b0, 4};
        vt[8]  = '{4'd12, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF,  32'd0,          1'b1, 1};
        vt[9]  = '{4'd0, 5'd1, 5'd2, 5'd9,  32'd0,          32'd12,         1'b0, 4};
        vt[10] = '{4'd9, 5'd0, 5'd0, 5'd1,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 2};
        vt[11] = '{4'd9, 5'd0, 5'd0, 5'd2,  32'd3,          32'd3,          1'b0, 2};
        vt[12] = '{4'd0, 5'd1, 5'd2, 5'd11, 32'd0,          32'd2,          1'b0, 4};
        vt[13] = '{4'd6, 5'd1, 5'd2, 5'd9,  32'd0,          32'hFFFF_FFFD,  1'b0, 5};
        vt[14] = '{4'd7, 5'd0, 5'd0, 5'd4,  32'd0,          32'd2,          1'b0, 2};
        vt[15] = '{4'd8, 5'd0, 5'd0, 5'd10, 32'd0,          32'hFFFF_FFFD,  1'b0, 2};
        vt[16] = '{4'd9, 5'd0, 5'd0, 5'd0,  32'd9,          32'd9,          1'b0, 2};
        vt[17] = '{4'd0, 5'd0, 5'd0, 5'd5,  32'd0,          32'd0,          1'b0, 4};

        // Reset state while clear is held low.
        repeat (2) @(negedge clock);
        check("reset_ready", {61'd0, rdy0, rdy1, rdy2}, 64'd7);
        check("reset_rsp_valid", {61'd0, rv0, rv1, rv2}, 64'd0);
        check("reset_rsp_err", {61'd0, re0, re1, re2}, 64'd0);
        check("reset_rsp_data", {rd0, rd1 | {16'd0, rd2}}, 64'd0);
        check("reset_bus_mon", {bm0, bm1 | {16'd0, bm2}}, 64'd0);
        clear = 1'b1;
        @(negedge clock);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            do_cmd(vt[i].op, vt[i].ra, vt[i].rb, vt[i].rc, vt[i].imm, 1'b0);
            check($sformatf("vec%0d_data", i), 64'(cap_d[0]), 64'(vt[i].data));
            check($sformatf("vec%0d_err", i), 64'(cap_err), 64'(vt[i].err));
            check($sformatf("vec%0d_lat", i), 64'(cap_lat), 64'(vt[i].lat));
        end
        check("r0_writable_add", 64'(cap_d[1]), 64'd18);

        // cmd_valid held high across back-to-back commands.
        do_cmd(4'd9, 5'd0, 5'd0, 5'd12, 32'd11, 1'b1);
        do_cmd(4'd0, 5'd12, 5'd12, 5'd12, 32'd0, 1'b1);
        check("hold_add_aliased", 64'(cap_d[0]), 64'd22);
        do_cmd(4'd6, 5'd12, 5'd12, 5'd13, 32'd0, 1'b0);
        check("hold_mul", 64'(cap_d[0]), 64'd484);

        // Reset dropped in T2 of an ADD.
        do_cmd(4'd9, 5'd0, 5'd0, 5'd3, 32'd9, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        cmd_ra    = 5'd3;
        cmd_rb    = 5'd3;
        cmd_rc    = 5'd6;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("abort_ready", {61'd0, rdy0, rdy1, rdy2}, 64'd7);
        check("abort_rsp_valid", {61'd0, rv0, rv1, rv2}, 64'd0);
        check("abort_rsp_data", {rd0, rd1 | {16'd0, rd2}}, 64'd0);
        check("abort_bus_mon", {bm0, bm1 | {16'd0, bm2}}, 64'd0);
        model_reset();
        @(negedge clock);
        clear = 1'b1;
        begin
            bit quiet = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clock);
                if (rv0 || rv1 || rv2 || !rdy0) quiet = 1'b0;
            end
            check("abort_no_rsp", 64'(quiet), 64'd1);
        end

        // Every register reads zero after the abort.
        for (int i = 0; i < 32; i++) begin
            do_cmd(4'd3, 5'(i), 5'(i), 5'd0, 32'd0, 1'b0);
            check($sformatf("readback_r%0d", i), {cap_d[0], cap_d[2]}, 64'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            bit         hold;
            if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(10, 15));
            else                           op = 4'($urandom_range(0, 9));
            hold = (i != 79) && ($urandom_range(0, 3) == 0);
            do_cmd(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), $urandom, hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_datapath_gen.md
BUS_DATAPATH_GEN -- requirements
Module: bus_datapath_gen

Interface
REQ-001 Parameter DATA_W, default 32: width of bus, general registers, HI, LO and rsp_data.
REQ-002 Parameter NUM_REGS, default 16: general register count; power of two, at least 2; RA_W = clog2(NUM_REGS).
REQ-003 Parameter R0_ZERO, default 1: when 1, R0 reads as zero and writes to R0 are discarded.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 clear  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 cmd_op  in  4  operation code.
REQ-010 cmd_ra, cmd_rb, cmd_rc  in  RA_W each  source A, source B and destination register indices.
REQ-011 cmd_imm  in  DATA_W  immediate value for LDI.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_data  out  DATA_W  value written to R[rc]; for MUL, the LO value.
REQ-014 rsp_err  out  1  illegal opcode, valid with rsp_valid.
REQ-015 bus_mon  out  DATA_W  current internal bus value; zero when no source is driving.

Function
REQ-016 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 MUL (unsigned, 2*DATA_W result), 7 MFHI, 8 MFLO, 9 LDI; 10-15 illegal.
REQ-017 A shall be R[ra] and B shall be R[rb]; shift amount = B[clog2(DATA_W)-1:0].
REQ-018 Single shared bus; exactly one source drives it per cycle, selected by the FSM.
REQ-019 FSM states: IDLE, T1, T2, T3, T4, RESP.
REQ-020 cmd_ready = (state==IDLE); on accept, latch op, ra, rb, rc and imm, then go to T1 (or RESP for an illegal opcode).
REQ-021 ALU ops 0-5 sequence:
  - T1: bus=R[ra], Y<=bus.
  - T2: bus=R[rb], Z<=zero-extended ALU(Y, bus).
  - T3: bus=Zlow, R[rc]<=bus.
  - Then RESP.
REQ-022 MUL sequence:
  - T1 and T2 as ALU ops, with Z<=Y*bus.
  - T3: bus=Zlow, LO<=bus, R[rc]<=bus.
  - T4: bus=Zhigh, HI<=bus.
  - Then RESP.
REQ-023 MFHI/MFLO/LDI sequence: T1: bus=HI, LO or imm respectively, R[rc]<=bus; then RESP.
REQ-024 Latency from the accept edge to rsp_valid: 4 cycles for ALU ops, 5 for MUL, 2 for MFHI/MFLO/LDI, 1 for illegal.
REQ-025 RESP: rsp_valid=1 for exactly one cycle; no backpressure; return to IDLE on the next cycle.
REQ-026 Illegal opcode: rsp_err=1, rsp_data=0, no register, HI, LO, Y or Z change.
REQ-027 rsp_data holds its last value outside RESP; rsp_err=0 on every legal-op response.
REQ-028 ADD/SUB/SHL wrap modulo 2^DATA_W; no flags.
REQ-029 rc equal to ra or rb: sources are read before the write, so old values are used.
REQ-030 R0_ZERO=1 with rc=0: the write is discarded, but rsp_data still reports the bus value.

Reset
REQ-031 While clear is low, independent of clock:
  - state=IDLE.
  - All general registers, HI, LO, Y and Z = 0.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - cmd_ready=1 and bus_mon=0.
REQ-032 Reset asserted mid-sequence aborts the command: no response and no later partial write.

Structure
REQ-033 Shared package bdp_pkg holds the opcode enum, the FSM state enum and the bus-source select enum.
REQ-034 One sub-module, bdp_alu: combinational, parametrised by DATA_W, producing a 2*DATA_W result from op, Y and bus.

Verification
REQ-035 Reset, then LDI 5->R1, then LDI 7->R2, then ADD ra=1 rb=2 rc=3 -> rsp_data=12, asserted 4 cycles after accept.
REQ-036 LDI 0xFFFF_FFFF->R1, LDI 3->R2, then MUL ra=1 rb=2 -> LO=0xFFFF_FFFD, then MFHI rc=4 -> rsp_data=2.
REQ-037 cmd_op=12 -> rsp_valid with rsp_err=1 one cycle after accept; the next ADD shows the register file unchanged.
REQ-038 LDI 9->R0 with R0_ZERO=1, then ADD ra=0 rb=0 rc=5 -> rsp_data=0; repeat with R0_ZERO=0 -> rsp_data=18.
REQ-039 Drop clear in T2 of an ADD -> no rsp_valid; after release, cmd_ready=1 and all registers read 0.
REQ-040 Hold cmd_valid high through a sequence -> cmd_ready=0 from T1 to RESP and the second command is accepted only in IDLE; also rerun at NUM_REGS=32, DATA_W=16.
